// File: rtl/cfs_event_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cfs_event_sched : per-source edge detectors feeding sticky pending flags,
//                   serialized round-robin onto a valid/ready event channel.
// Optional feature macro: CFS_EVT_OVF_CNT_EN (saturating overflow counter).
// Revision: 1.0
// ----------------------------------------------------------------------------
module cfs_event_sched #(
  parameter int N_SRC = 4,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1,
  parameter int OVF_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_SRC-1:0] src_i,
  input  logic [N_SRC-1:0] edge_sel_i,
  input  logic [N_SRC-1:0] en_i,
  input  logic [N_SRC-1:0] clr_i,
  output logic             evt_valid_o,
  output logic [ID_W-1:0]  evt_id_o,
  input  logic             evt_ready_i,
  output logic [N_SRC-1:0] pending_o,
  output logic             irq_o
`ifdef CFS_EVT_OVF_CNT_EN
  ,
  output logic [OVF_W-1:0] ovf_cnt_o
`endif
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state_q;
  logic [N_SRC-1:0] dly_q;
  logic [N_SRC-1:0] pending_q;
  logic [N_SRC-1:0] pending_d;
  logic             primed_q;
  logic             evt_valid_q;
  logic [ID_W-1:0]  evt_id_q;
  logic [ID_W-1:0]  last_grant_q;

  logic [N_SRC-1:0] det;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] hs_vec;
  logic             hs;
  logic             sel_found;
  logic [ID_W-1:0]  sel_id;
  int               scan_idx;

  // primed_q masks the first cycle after reset, when dly_q does not yet track src_i
  assign det = {N_SRC{primed_q}} & en_i &
               ((edge_sel_i & src_i & ~dly_q) | (~edge_sel_i & ~src_i & dly_q));
  assign hs  = evt_valid_q & evt_ready_i;
  assign req = pending_q & en_i;

  always_comb begin
    hs_vec = '0;
    for (int i = 0; i < N_SRC; i++) begin
      hs_vec[i] = hs && (int'(evt_id_q) == i);
    end
  end

  assign pending_d = det | (pending_q & ~clr_i & ~hs_vec);

  // Round-robin scan starting just after the last granted index
  always_comb begin
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = 0;
    for (int k = 1; k <= N_SRC; k++) begin
      scan_idx = (int'(last_grant_q) + k) % N_SRC;
      if (!sel_found && req[scan_idx]) begin
        sel_found = 1'b1;
        sel_id    = ID_W'(scan_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dly_q        <= '0;
      primed_q     <= 1'b0;
      pending_q    <= '0;
      state_q      <= IDLE;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      last_grant_q <= ID_W'(N_SRC - 1);
    end else begin
      dly_q     <= src_i;
      primed_q  <= 1'b1;
      pending_q <= pending_d;
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            evt_id_q    <= sel_id;
            evt_valid_q <= 1'b1;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (hs) begin
            evt_valid_q  <= 1'b0;
            last_grant_q <= evt_id_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_id_o    = evt_id_q;
  assign pending_o   = pending_q;
  assign irq_o       = |(pending_q & en_i);

`ifdef CFS_EVT_OVF_CNT_EN
  localparam int SUM_W = OVF_W + 6;

  logic [OVF_W-1:0] ovf_cnt_q;
  logic [OVF_W-1:0] ovf_cnt_d;
  logic [SUM_W-1:0] ovf_sum;
  logic [N_SRC-1:0] ovf_hit;

  // An edge landing on an already-pending bit that is not being cleared is lost
  assign ovf_hit = det & pending_q & ~clr_i & ~hs_vec;

  always_comb begin
    ovf_sum = SUM_W'(ovf_cnt_q);
    for (int i = 0; i < N_SRC; i++) begin
      ovf_sum = ovf_sum + SUM_W'(ovf_hit[i]);
    end
    if (ovf_sum > SUM_W'({OVF_W{1'b1}})) begin
      ovf_cnt_d = '1;
    end else begin
      ovf_cnt_d = ovf_sum[OVF_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt_o = ovf_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cfs_event_sched.sv
`default_nettype none
// Testbench for cfs_event_sched: directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the scheduler.
module tb_cfs_event_sched;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_n;
  logic [N-1:0]   src, esel, en, clr;
  logic           ready;
  logic           valid;
  logic [IDW-1:0] id;
  logic [N-1:0]   pend;
  logic           irq;
`ifdef CFS_EVT_OVF_CNT_EN
  logic [7:0]     ovf;
`endif

  cfs_event_sched #(.N_SRC(N), .ID_W(IDW), .OVF_W(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src_i       (src),
    .edge_sel_i  (esel),
    .en_i        (en),
    .clr_i       (clr),
    .evt_valid_o (valid),
    .evt_id_o    (id),
    .evt_ready_i (ready),
    .pending_o   (pend),
    .irq_o       (irq)
`ifdef CFS_EVT_OVF_CNT_EN
    ,
    .ovf_cnt_o   (ovf)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state: what the outputs must show after the next edge
  bit [N-1:0] m_dly, m_pend;
  bit         m_primed, m_valid;
  int         m_id, m_lg, m_ovf;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [N-1:0] np;
    bit         hs, ev, cleared, found;
    int         novf, idx;
    if (!reset_n) begin
      m_dly = '0; m_pend = '0; m_primed = 0; m_valid = 0;
      m_id = 0; m_lg = N - 1; m_ovf = 0;
    end else begin
      hs   = m_valid && ready;
      novf = 0;
      np   = '0;
      for (int i = 0; i < N; i++) begin
        ev      = m_primed && en[i] && (src[i] != m_dly[i]) && (src[i] == esel[i]);
        cleared = clr[i] || (hs && m_id == i);
        np[i]   = ev || (m_pend[i] && !cleared);
        if (ev && m_pend[i] && !cleared) novf++;
      end
      if (m_valid) begin
        if (hs) begin
          m_valid = 0;
          m_lg    = m_id;
        end
      end else begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          idx = (m_lg + k) % N;
          if (!found && m_pend[idx] && en[idx]) begin
            found = 1; m_id = idx; m_valid = 1;
          end
        end
      end
      m_pend   = np;
      m_ovf    = (m_ovf + novf > 255) ? 255 : m_ovf + novf;
      m_dly    = src;
      m_primed = 1;
    end
  endtask

  task automatic compare();
    check("pending", int'(pend), int'(m_pend));
    check("evt_valid", int'(valid), int'(m_valid));
    if (m_valid) check("evt_id", int'(id), m_id);
    check("irq", int'(irq), int'(|(m_pend & en)));
`ifdef CFS_EVT_OVF_CNT_EN
    check("ovf_cnt", int'(ovf), m_ovf);
`endif
  endtask

  // Inputs are held across one posedge; outputs are checked at the following negedge
  task automatic tick();
    model_step();
    @(negedge clk);
    compare();
  endtask

  initial begin
    reset_n = 0; src = '1; esel = '1; en = '1; clr = '0; ready = 0;
    @(negedge clk);
    tick(); tick();
    check("rst_pending", int'(pend), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_id", int'(id), 0);
    check("rst_irq", int'(irq), 0);

    // Priming: sources already high at release must not register as edges
    reset_n = 1;
    repeat (3) begin
      tick();
      check("prime_pending", int'(pend), 0);
      check("prime_valid", int'(valid), 0);
    end

    // Single rising edge on source 2 with consumer ready
    ready = 1; src = 4'b0000; tick();
    check("fall_ignored", int'(pend), 0);
    src = 4'b0100; tick();
    check("s2_pend", int'(pend), 4'b0100);
    check("s2_valid_early", int'(valid), 0);
    tick();
    check("s2_valid", int'(valid), 1);
    check("s2_id", int'(id), 2);
    tick();
    check("s2_pend_clr", int'(pend), 0);
    check("s2_valid_drop", int'(valid), 0);

    // Three simultaneous edges, consumer stalled then ready
    reset_n = 0; src = 4'b0000; ready = 0; tick();
    reset_n = 1; tick();
    src = 4'b1011; tick();
    check("m3_pend", int'(pend), 4'b1011);
    repeat (5) begin
      tick();
      check("m3_hold_valid", int'(valid), 1);
      check("m3_hold_id", int'(id), 0);
    end
    ready = 1; tick();
    check("m3_bubble1", int'(valid), 0);
    check("m3_pend1", int'(pend), 4'b1010);
    tick();
    check("m3_id1", int'(id), 1);
    tick();
    check("m3_bubble2", int'(valid), 0);
    tick();
    check("m3_id3", int'(id), 3);
    tick();
    check("m3_done", int'(pend), 0);

    // Wrap-around after granting id 3
    src = 4'b0000; tick();
    src = 4'b1001; tick();
    check("wrap_pend", int'(pend), 4'b1001);
    tick();
    check("wrap_valid", int'(valid), 1);
    check("wrap_id", int'(id), 0);
    tick(); tick();
    check("wrap_id3", int'(id), 3);
    tick();

    // Disabled source keeps its pending flag but is never offered
    src = 4'b0000; tick();
    src = 4'b0010; tick();
    en = 4'b1101;
    repeat (4) begin
      tick();
      check("dis_valid", int'(valid), 0);
      check("dis_pend", int'(pend), 4'b0010);
      check("dis_irq", int'(irq), 0);
    end

    // Set beats clear; clear during offer does not withdraw it
    clr = 4'b0010; tick(); clr = '0;
    check("clr_pend", int'(pend), 0);
    src = 4'b0000; tick();
    ready = 0; en = 4'b1111; src = 4'b0010; clr = 4'b0010; tick(); clr = '0;
    check("setwins_pend", int'(pend), 4'b0010);
    tick();
    check("off1_valid", int'(valid), 1);
    check("off1_id", int'(id), 1);
    clr = 4'b0010; tick(); clr = '0;
    check("off1_held", int'(valid), 1);
    check("off1_held_id", int'(id), 1);
    check("off1_pend", int'(pend), 0);
    ready = 1; tick();
    check("off1_done", int'(valid), 0);

`ifdef CFS_EVT_OVF_CNT_EN
    // Overflow counting and saturation on source 0
    reset_n = 0; src = '0; ready = 0; tick();
    reset_n = 1; tick();
    repeat (3) begin src = 4'b0001; tick(); src = 4'b0000; tick(); end
    check("ovf_two", int'(ovf), 2);
    repeat (260) begin src = 4'b0001; tick(); src = 4'b0000; tick(); end
    check("ovf_sat", int'(ovf), 255);
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      src     = 4'($urandom);
      if ($urandom_range(0, 15) == 0) esel = 4'($urandom);
      en      = 4'($urandom) | 4'($urandom);
      clr     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      ready   = ($urandom_range(0, 2) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
